// File: rtl/me_pkg.sv
// ============================================================================
// Module      : me_pkg
// Description : Shared motion-estimation defaults and the SAD-min FSM states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package me_pkg;

    localparam int c_SAD_W_DEF   = 16;
    localparam int c_COL_W_DEF   = 5;
    localparam int c_ROW_W_DEF   = 7;
    localparam int c_ZMV_COL_DEF = 16;
    localparam int c_ZMV_ROW_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2
    } state_e;

endpackage : me_pkg

`default_nettype wire

// File: rtl/sad_min_select_cell.sv
// ============================================================================
// Module      : sad_min_cell
// Description : One partition's running-minimum register with first-load flag.
//               SAD_MIN_ZERO_MV_PRIORITY_EN lets the zero-MV candidate win ties.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sad_min_cell
    import me_pkg::*;
#(
    parameter int SAD_W   = c_SAD_W_DEF,
    parameter int COL_W   = c_COL_W_DEF,
    parameter int ROW_W   = c_ROW_W_DEF,
    parameter int ZMV_COL = c_ZMV_COL_DEF,
    parameter int ZMV_ROW = c_ZMV_ROW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_arm,
    input  logic             i_valid,
    input  logic [SAD_W-1:0] i_sad,
    input  logic [COL_W-1:0] i_col,
    input  logic [ROW_W-1:0] i_row,
    output logic [SAD_W-1:0] o_min_sad,
    output logic [COL_W-1:0] o_best_col,
    output logic [ROW_W-1:0] o_best_row
);

    logic [SAD_W-1:0] r_min_sad_q;
    logic [COL_W-1:0] r_best_col_q;
    logic [ROW_W-1:0] r_best_row_q;
    logic             r_first_q;

    logic             w_less;
    logic             w_tie_win;
    logic             w_load;

    assign w_less = (i_sad < r_min_sad_q);

`ifdef SAD_MIN_ZERO_MV_PRIORITY_EN
    localparam logic [COL_W-1:0] c_ZMV_COL = COL_W'(ZMV_COL);
    localparam logic [ROW_W-1:0] c_ZMV_ROW = ROW_W'(ZMV_ROW);
    assign w_tie_win = (i_col == c_ZMV_COL) && (i_row == c_ZMV_ROW) &&
                       (i_sad == r_min_sad_q);
`else
    assign w_tie_win = 1'b0;
`endif

    assign w_load = i_valid && (r_first_q || w_less || w_tie_win);

    // Arming takes priority: the caller already suppresses i_valid on restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min_sad_q  <= '0;
            r_best_col_q <= '0;
            r_best_row_q <= '0;
            r_first_q    <= 1'b0;
        end else if (i_arm) begin
            r_first_q    <= 1'b1;
        end else if (w_load) begin
            r_min_sad_q  <= i_sad;
            r_best_col_q <= i_col;
            r_best_row_q <= i_row;
            r_first_q    <= 1'b0;
        end
    end

    assign o_min_sad  = r_min_sad_q;
    assign o_best_col = r_best_col_q;
    assign o_best_row = r_best_row_q;

endmodule : sad_min_cell

`default_nettype wire

// File: rtl/sad_min_select.sv
// ============================================================================
// Module      : sad_min_select
// Description : Per-partition minimum-SAD tracker over a search window; FSM,
//               candidate stage and output packing. Option macro:
//               SAD_MIN_ZERO_MV_PRIORITY_EN (zero-MV wins ties).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sad_min_select
    import me_pkg::*;
#(
    parameter int NUM_PART = 4,
    parameter int SAD_W    = c_SAD_W_DEF,
    parameter int COL_W    = c_COL_W_DEF,
    parameter int ROW_W    = c_ROW_W_DEF,
    parameter int ZMV_COL  = c_ZMV_COL_DEF,
    parameter int ZMV_ROW  = c_ZMV_ROW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      search_start,
    input  logic                      sad_valid,
    input  logic                      sad_last,
    input  logic [NUM_PART*SAD_W-1:0] sad_in,
    input  logic [COL_W-1:0]          search_column_count,
    input  logic [ROW_W-1:0]          search_row_count,
    output logic [NUM_PART*SAD_W-1:0] min_sad,
    output logic [NUM_PART*COL_W-1:0] best_col,
    output logic [NUM_PART*ROW_W-1:0] best_row,
    output logic                      busy,
    output logic                      done
);

    state_e                    r_state_q, w_state_d;
    logic                      r_done_q,  w_done_d;

    logic                      r_s1_valid_q, w_s1_valid_d;
    logic [NUM_PART*SAD_W-1:0] r_s1_sad_q;
    logic [COL_W-1:0]          r_s1_col_q;
    logic [ROW_W-1:0]          r_s1_row_q;

    logic                      w_accept;
    logic                      w_cell_valid;

    // A candidate is taken while searching, or alongside the start pulse.
    assign w_accept     = sad_valid && (search_start || (r_state_q == SEARCH));
    assign w_s1_valid_d = w_accept;
    // Restart discards whatever candidate is still in flight.
    assign w_cell_valid = r_s1_valid_q && !search_start;

    always_comb begin
        w_state_d = r_state_q;
        w_done_d  = 1'b0;
        if (search_start) begin
            w_state_d = (sad_valid && sad_last) ? DRAIN : SEARCH;
        end else begin
            case (r_state_q)
                IDLE: begin
                    w_state_d = IDLE;
                end
                SEARCH: begin
                    if (sad_valid && sad_last) begin
                        w_state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= IDLE;
            r_done_q     <= 1'b0;
            r_s1_valid_q <= 1'b0;
            r_s1_sad_q   <= '0;
            r_s1_col_q   <= '0;
            r_s1_row_q   <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_done_q     <= w_done_d;
            r_s1_valid_q <= w_s1_valid_d;
            if (w_accept) begin
                r_s1_sad_q <= sad_in;
                r_s1_col_q <= search_column_count;
                r_s1_row_q <= search_row_count;
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_PART; p++) begin : g_cell
            sad_min_cell #(
                .SAD_W   (SAD_W),
                .COL_W   (COL_W),
                .ROW_W   (ROW_W),
                .ZMV_COL (ZMV_COL),
                .ZMV_ROW (ZMV_ROW)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .i_arm      (search_start),
                .i_valid    (w_cell_valid),
                .i_sad      (r_s1_sad_q[p*SAD_W +: SAD_W]),
                .i_col      (r_s1_col_q),
                .i_row      (r_s1_row_q),
                .o_min_sad  (min_sad[p*SAD_W +: SAD_W]),
                .o_best_col (best_col[p*COL_W +: COL_W]),
                .o_best_row (best_row[p*ROW_W +: ROW_W])
            );
        end
    endgenerate

    assign busy = (r_state_q != IDLE);
    assign done = r_done_q;

endmodule : sad_min_select

`default_nettype wire

// File: tb/tb_sad_min_select.sv
// ============================================================================
// Module      : tb_sad_min_select
// Description : Directed self-checking bench for sad_min_select (4 partitions).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sad_min_select;

    localparam int NP = 4;
    localparam int SW = 16;
    localparam int CW = 5;
    localparam int RW = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              search_start;
    logic              sad_valid;
    logic              sad_last;
    logic [NP*SW-1:0]  sad_in;
    logic [CW-1:0]     search_column_count;
    logic [RW-1:0]     search_row_count;
    logic [NP*SW-1:0]  min_sad;
    logic [NP*CW-1:0]  best_col;
    logic [NP*RW-1:0]  best_row;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    sad_min_select #(
        .NUM_PART (NP),
        .SAD_W    (SW),
        .COL_W    (CW),
        .ROW_W    (RW),
        .ZMV_COL  (16),
        .ZMV_ROW  (64)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .search_start        (search_start),
        .sad_valid           (sad_valid),
        .sad_last            (sad_last),
        .sad_in              (sad_in),
        .search_column_count (search_column_count),
        .search_row_count    (search_row_count),
        .min_sad             (min_sad),
        .best_col            (best_col),
        .best_row            (best_row),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic v, input logic l,
                         input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                         input logic [SW-1:0] s2, input logic [SW-1:0] s3,
                         input int col, input int row);
        search_start        = st;
        sad_valid           = v;
        sad_last            = l;
        sad_in              = {s3, s2, s1, s0};
        search_column_count = CW'(col);
        search_row_count    = RW'(row);
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0);
    endtask

    int d0;

    initial begin
        rst = 1'b1;
        idle_in();
        cyc(); cyc();
        chk("reset_min_sad", 64'(min_sad), 64'd0);
        chk("reset_best_col", 64'(best_col), 64'd0);
        chk("reset_best_row", 64'(best_row), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        cyc();

        // Valid+last in IDLE must be ignored
        drive(1'b0, 1'b1, 1'b1, 16'd5, 16'd5, 16'd5, 16'd5, 2, 2);
        cyc();
        idle_in();
        cyc(); cyc();
        chk("idle_ignore_busy", 64'(busy), 64'd0);
        chk("idle_ignore_done_cnt", 64'(done_cnt), 64'd0);
        chk("idle_ignore_min", 64'(min_sad), 64'd0);

        // Window 1: four candidates, row 0
        d0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0);
        cyc();
        chk("w1_busy_after_start", 64'(busy), 64'd1);
        drive(1'b0, 1'b1, 1'b0, 16'd500, 16'd50, 16'd7, 16'd1000, 0, 0); cyc();
        drive(1'b0, 1'b1, 1'b0, 16'd300, 16'd60, 16'd7, 16'd900,  1, 0); cyc();
        drive(1'b0, 1'b1, 1'b0, 16'd300, 16'd40, 16'd7, 16'd800,  2, 0); cyc();
        drive(1'b0, 1'b1, 1'b1, 16'd400, 16'd40, 16'd7, 16'd700,  3, 0); cyc();
        idle_in();
        chk("w1_done_early", 64'(done), 64'd0);
        chk("w1_busy_drain", 64'(busy), 64'd1);
        cyc();
        chk("w1_done", 64'(done), 64'd1);
        chk("w1_busy_fall", 64'(busy), 64'd0);
        chk("w1_min_sad", 64'(min_sad), {16'd700, 16'd7, 16'd40, 16'd300});
        chk("w1_best_col", 64'(best_col), 64'({5'd3, 5'd0, 5'd2, 5'd1}));
        chk("w1_best_row", 64'(best_row), 64'd0);
        cyc();
        chk("w1_done_pulse", 64'(done), 64'd0);
        chk("w1_min_hold", 64'(min_sad), {16'd700, 16'd7, 16'd40, 16'd300});
        chk("w1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Window 2: single candidate of all-ones
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0); cyc();
        drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 7, 20); cyc();
        idle_in(); cyc();
        chk("w2_done", 64'(done), 64'd1);
        chk("w2_min_sad", 64'(min_sad), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w2_best_col", 64'(best_col), 64'({5'd7, 5'd7, 5'd7, 5'd7}));
        chk("w2_best_row", 64'(best_row), 64'({7'd20, 7'd20, 7'd20, 7'd20}));

        // Window 3: restart mid-window
        cyc();
        d0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0); cyc();
        drive(1'b0, 1'b1, 1'b0, 16'd10, 16'd10, 16'd10, 16'd10, 1, 1); cyc();
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0); cyc();
        drive(1'b0, 1'b1, 1'b0, 16'd200, 16'd200, 16'd200, 16'd200, 2, 1); cyc();
        drive(1'b0, 1'b1, 1'b1, 16'd150, 16'd250, 16'd150, 16'd150, 3, 1); cyc();
        idle_in(); cyc();
        chk("w3_done", 64'(done), 64'd1);
        chk("w3_min_sad", 64'(min_sad), {16'd150, 16'd150, 16'd200, 16'd150});
        chk("w3_best_col", 64'(best_col), 64'({5'd3, 5'd3, 5'd2, 5'd3}));
        cyc(); cyc(); cyc();
        chk("w3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Window 4: start + valid + last together
        drive(1'b1, 1'b1, 1'b1, 16'd77, 16'd77, 16'd77, 16'd77, 5, 9); cyc();
        idle_in();
        chk("w4_busy", 64'(busy), 64'd1);
        chk("w4_done_early", 64'(done), 64'd0);
        cyc();
        chk("w4_done", 64'(done), 64'd1);
        chk("w4_min_sad", 64'(min_sad), {16'd77, 16'd77, 16'd77, 16'd77});
        chk("w4_best_col", 64'(best_col), 64'({5'd5, 5'd5, 5'd5, 5'd5}));
        chk("w4_best_row", 64'(best_row), 64'({7'd9, 7'd9, 7'd9, 7'd9}));
        cyc();

        // Reset during DRAIN
        d0 = done_cnt;
        drive(1'b1, 1'b1, 1'b1, 16'd33, 16'd33, 16'd33, 16'd33, 4, 4); cyc();
        idle_in();
        rst = 1'b1;
        cyc();
        chk("rst_drain_min", 64'(min_sad), 64'd0);
        chk("rst_drain_col", 64'(best_col), 64'd0);
        chk("rst_drain_row", 64'(best_row), 64'd0);
        chk("rst_drain_busy", 64'(busy), 64'd0);
        chk("rst_drain_done", 64'(done), 64'd0);
        rst = 1'b0;
        cyc(); cyc();
        chk("rst_drain_no_done", 64'(done_cnt - d0), 64'd0);

        // Window 6: tie at ordinary position then at zero-MV position
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0); cyc();
        drive(1'b0, 1'b1, 1'b0, 16'd120, 16'd120, 16'd120, 16'd120, 3, 10); cyc();
        drive(1'b0, 1'b1, 1'b1, 16'd120, 16'd120, 16'd120, 16'd120, 16, 64); cyc();
        idle_in(); cyc();
        chk("w6_done", 64'(done), 64'd1);
        chk("w6_min_sad", 64'(min_sad), {16'd120, 16'd120, 16'd120, 16'd120});
`ifdef SAD_MIN_ZERO_MV_PRIORITY_EN
        chk("w6_best_col", 64'(best_col), 64'({5'd16, 5'd16, 5'd16, 5'd16}));
        chk("w6_best_row", 64'(best_row), 64'({7'd64, 7'd64, 7'd64, 7'd64}));
`else
        chk("w6_best_col", 64'(best_col), 64'({5'd3, 5'd3, 5'd3, 5'd3}));
        chk("w6_best_row", 64'(best_row), 64'({7'd10, 7'd10, 7'd10, 7'd10}));
`endif
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sad_min_select

`default_nettype wire

// File: doc/sad_min_select.md
# sad_min_select

Downstream stage of the basic-layer search engine. Consumes the packed per-partition SAD vectors the search array emits once per candidate position, and for every partition tracks the minimum SAD and the search counters at which it occurred. At the end of a search window it presents the winning SAD and position per partition and pulses `done`. One instance is used per partition shape, e.g. 16x16 with `NUM_PART=4`, `SAD_W=16`.

## Interface
- `NUM_PART`, 4: partitions packed in `sad_in`.
- `SAD_W`, 16: bits per partition SAD.
- `COL_W`, 5: width of the search column counter.
- `ROW_W`, 7: width of the search row counter.
- `ZMV_COL`, 16: column count of the zero motion vector (used only with the macro).
- `ZMV_ROW`, 64: row count of the zero motion vector (used only with the macro).
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `search_start` in 1: one-cycle pulse that opens a new search window.
- `sad_valid` in 1: `sad_in` and the counters hold a candidate this cycle.
- `sad_last` in 1: qualified by `sad_valid`; marks the final candidate of the window.
- `sad_in` in NUM_PART*SAD_W: partition p occupies bits [p*SAD_W +: SAD_W].
- `search_column_count` in COL_W: candidate column.
- `search_row_count` in ROW_W: candidate row.
- `min_sad` out NUM_PART*SAD_W: best SAD per partition, same packing as `sad_in`.
- `best_col` out NUM_PART*COL_W: column of the best SAD per partition.
- `best_row` out NUM_PART*ROW_W: row of the best SAD per partition.
- `busy` out 1: window open or pipeline draining.
- `done` out 1: one-cycle pulse; results are final.

## Operation
- State machine IDLE -> SEARCH -> DRAIN -> IDLE.
- IDLE: `sad_valid` is ignored. `search_start` moves to SEARCH and sets `first` on every partition cell.
- SEARCH: each `sad_valid` registers the candidate in stage 1, which holds the SAD vector, the counters and a `first` tag. A valid qualified by `sad_last` moves to DRAIN.
- DRAIN: lasts one cycle while stage 2 absorbs the last candidate, then returns to IDLE with `done`=1.
- Stage 2, per partition: load the candidate if `first` is set or candidate < current minimum (unsigned compare). Otherwise hold. `first` clears after the first load.
- Ties: strict less-than, so the earliest candidate wins.
- `search_start` in SEARCH or DRAIN restarts the window. The in-flight stage-1 entry is discarded and `first` is re-armed. No `done` is produced for the aborted window.
- `search_start` together with `sad_valid`: that candidate is the first of the new window.
- `search_start` together with `sad_valid` and `sad_last`: a single-candidate window, so `done` follows as for any last candidate.
- `sad_valid` with `sad_last` in IDLE is ignored.
- Outputs hold their last results in IDLE until the next window's first load.

## Timing
- Reset: state IDLE; `min_sad`, `best_col`, `best_row` are all 0; `busy`=0, `done`=0; stage 1 invalid.
- Candidate accepted at edge N is registered at N. It updates the outputs at edge N+1.
- For the last candidate accepted at edge N, `done` is high during cycle N+2. `min_sad`, `best_col` and `best_row` are final from edge N+1 and are stable while `done` is high.
- `busy` rises the cycle after `search_start` and falls with `done`.
- Throughput: one candidate per cycle, with no back-pressure.
- Reset during SEARCH or DRAIN returns to the reset state next edge, with no `done`.

## Configuration
- `SAD_MIN_ZERO_MV_PRIORITY_EN` defined: a candidate at `search_column_count==ZMV_COL` and `search_row_count==ZMV_ROW` also wins on a tie (candidate <= minimum).
- Not defined: the compare is strict less-than for every candidate, and `ZMV_COL`/`ZMV_ROW` are unused.

## Structure
- Shared package `me_pkg`: default widths `COL_W`/`ROW_W`/`SAD_W`, the `ZMV_*` defaults, and the state enum `{IDLE, SEARCH, DRAIN}`.
- Sub-module `sad_min_cell`: one partition's compare/update register plus `first` flag, generated `NUM_PART` times. The top level holds the FSM, stage 1 and output packing.

## Test plan
- Single window, `NUM_PART=4`. Partition 0 gets SADs 500, 300, 300, 400 at cols 0..3, row 0, with the last on col 3 -> `min_sad[0]`=300, `best_col[0]`=1, `done` two cycles after the last.
- First-candidate load: the only candidate has SAD 16'hFFFF on every partition -> all partitions hold 16'hFFFF at that position.
- Restart: `search_start` mid-window after SAD 10, then new SADs 200 and 150 -> result is 150, and only one `done` is produced.
- Start, valid and last in the same cycle with SAD 77 at col 5, row 9 -> `done` in cycle +2, and outputs show 77/5/9.
- Reset asserted in DRAIN -> next cycle all outputs 0, `busy`=0, and no `done`.
- With the macro: equal SAD 120 at (3,10), then at (`ZMV_COL`,`ZMV_ROW`) -> best position is (16,64). Without the macro -> (3,10).
